cla_pipe_addsub: RTL

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined adder/subtractor, SEG bits per stage using 4-bit carry-lookahead groups.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int LAT = WIDTH / SEG;

    logic             en;
    logic [WIDTH-1:0] bx;
    logic             cx;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign bx       = b ^ {WIDTH{sub}};
    assign cx       = sub | ci;

    // c[i] is the carry into bit i; groups use flat two-level equations, group carries ripple
    function automatic logic [SEG:0] carries(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic c0);
        logic [SEG:0] c;
        logic [3:0]   g;
        logic [3:0]   p;
        logic         cg;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < SEG / 4; j++) begin
            g  = x[4*j +: 4] & y[4*j +: 4];
            p  = x[4*j +: 4] | y[4*j +: 4];
            cg = c[4*j];
            c[4*j+1] = g[0] | (p[0] & cg);
            c[4*j+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
            c[4*j+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
            c[4*j+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cg);
        end
        return c;
    endfunction

    for (genvar k = 0; k < LAT; k++) begin : g_st
        // Operands still to be added, starting at this stage's segment
        localparam int R = WIDTH - k * SEG;
        logic [R-1:0]         ain;
        logic [R-1:0]         bin;
        logic                 cin;
        logic                 vin;
        logic [SEG:0]         car;
        logic [SEG-1:0]       sum;
        logic [(k+1)*SEG-1:0] s_nx;
        logic [(k+1)*SEG-1:0] s_r;
        logic                 c_r;
        logic                 v_r;

        if (k == 0) begin : g_in
            assign ain  = a;
            assign bin  = bx;
            assign cin  = cx;
            assign vin  = in_valid;
            assign s_nx = sum;
        end else begin : g_in
            assign ain  = g_st[k-1].g_fwd.a_r;
            assign bin  = g_st[k-1].g_fwd.b_r;
            assign cin  = g_st[k-1].c_r;
            assign vin  = g_st[k-1].v_r;
            assign s_nx = {sum, g_st[k-1].s_r};
        end

        assign car = carries(ain[SEG-1:0], bin[SEG-1:0], cin);
        assign sum = ain[SEG-1:0] ^ bin[SEG-1:0] ^ car[SEG-1:0];

        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
                s_r <= '0;
                c_r <= 1'b0;
            end else if (en) begin
                v_r <= vin;
                s_r <= s_nx;
                c_r <= car[SEG];
            end
        end

        if (k < LAT - 1) begin : g_fwd
            logic [R-SEG-1:0] a_r;
            logic [R-SEG-1:0] b_r;
            always_ff @(posedge clk) begin
                if (en) begin
                    a_r <= ain[R-1:SEG];
                    b_r <= bin[R-1:SEG];
                end
            end
        end else begin : g_last
            logic o_r;
            logic z_r;
            always_ff @(posedge clk) begin
                if (reset) begin
                    o_r <= 1'b0;
                    z_r <= 1'b0;
                end else if (en) begin
                    o_r <= car[SEG] ^ car[SEG-1];
                    z_r <= ~|s_nx;
                end
            end
        end
    end

    assign out_valid = g_st[LAT-1].v_r;
    assign s         = g_st[LAT-1].s_r;
    assign co        = g_st[LAT-1].c_r;
    assign ovf       = g_st[LAT-1].g_last.o_r;
    assign zero      = g_st[LAT-1].g_last.z_r;
endmodule
